// File: rtl/pmem_line_controller_pkg.sv
// Shared types and constants for the pmem line controller.
// Holds the line/word payload types, the FSM state encoding and beat/address helpers.
package pmem_line_controller_pkg;

  localparam int unsigned LC3B_WORDS_PER_LINE = 8;
  localparam int unsigned WORD_W              = 16;
  localparam int unsigned LINE_W              = 128;
  localparam int unsigned OFFSET_BITS         = 4;
  localparam int unsigned BEAT_W              = $clog2(LC3B_WORDS_PER_LINE);
  localparam int unsigned SEL_W               = $clog2(LINE_W);

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    READ_BEAT,
    WRITE_BEAT,
    RESP
  } lc3b_pmem_state_t;

  // Aligns a byte address down to the start of its line.
  function automatic lc3b_word line_base(input lc3b_word addr);
    return addr & ~lc3b_word'((2 ** OFFSET_BITS) - 1);
  endfunction

  // Byte offset of a word within the line.
  function automatic lc3b_word beat_offset(input beat_t beat);
    return lc3b_word'({beat, 1'b0});
  endfunction

  // Bit position of a word within the line.
  function automatic logic [SEL_W-1:0] beat_sel(input beat_t beat);
    return SEL_W'({beat, 4'b0000});
  endfunction

endpackage

// File: rtl/pmem_line_control.sv
// Line transaction FSM and beat counter.
// Produces registered memory strobes and the response pulse, plus load/capture enables.
module pmem_line_control
  import pmem_line_controller_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_read,
  input  logic  i_write,
  input  logic  i_mem_resp,
  output logic  o_mem_read,
  output logic  o_mem_write,
  output logic  o_pmem_resp,
  output logic  o_load_c,
  output logic  o_load_wdata_c,
  output logic  o_capture_c,
  output beat_t o_beat,
  output beat_t o_beat_next_c
);

  lc3b_pmem_state_t r_state;
  lc3b_pmem_state_t w_state_next;
  beat_t            r_beat;
  beat_t            w_beat_next;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_pmem_resp;
  logic             w_load;
  logic             w_load_wdata;
  logic             w_capture;

  // Strobes are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_pmem_resp <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_beat      <= w_beat_next;
      r_mem_read  <= (w_state_next == READ_BEAT);
      r_mem_write <= (w_state_next == WRITE_BEAT);
      r_pmem_resp <= (w_state_next == RESP);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    w_load       = 1'b0;
    w_load_wdata = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_read) begin
          w_state_next = READ_BEAT;
          w_beat_next  = '0;
          w_load       = 1'b1;
        end else if (i_write) begin
          w_state_next = WRITE_BEAT;
          w_beat_next  = '0;
          w_load       = 1'b1;
          w_load_wdata = 1'b1;
        end
      end
      READ_BEAT, WRITE_BEAT: begin
        if (i_mem_resp) begin
          w_capture   = (r_state == READ_BEAT);
          w_beat_next = r_beat + BEAT_W'(1);
          if (r_beat == BEAT_W'(LC3B_WORDS_PER_LINE - 1)) begin
            w_state_next = RESP;
          end
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign o_mem_read     = r_mem_read;
  assign o_mem_write    = r_mem_write;
  assign o_pmem_resp    = r_pmem_resp;
  assign o_load_c       = w_load;
  assign o_load_wdata_c = w_load_wdata;
  assign o_capture_c    = w_capture;
  assign o_beat         = r_beat;
  assign o_beat_next_c  = w_beat_next;

endmodule

// File: rtl/pmem_line_datapath.sv
// Base address, write line and read line registers with per-beat word muxing.
// Address and write word are registered from the next beat so they track the strobes.
module pmem_line_datapath
  import pmem_line_controller_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_load,
  input  logic     i_load_wdata,
  input  logic     i_capture,
  input  beat_t    i_beat,
  input  beat_t    i_beat_next,
  input  lc3b_word i_address,
  input  lc3b_line i_wdata,
  input  lc3b_word i_mem_rdata,
  output lc3b_line o_rdata,
  output lc3b_word o_mem_address,
  output lc3b_word o_mem_wdata
);

  lc3b_word r_base;
  lc3b_line r_wdata;
  lc3b_line r_rdata;
  lc3b_word r_mem_address;
  lc3b_word r_mem_wdata;
  lc3b_word w_base_next;
  lc3b_line w_wdata_next;

  always_comb begin
    w_base_next  = i_load ? line_base(i_address) : r_base;
    w_wdata_next = i_load_wdata ? i_wdata : r_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_base        <= w_base_next;
      r_wdata       <= w_wdata_next;
      r_mem_address <= w_base_next + beat_offset(i_beat_next);
      r_mem_wdata   <= w_wdata_next[beat_sel(i_beat_next) +: WORD_W];
      if (i_capture) begin
        r_rdata[beat_sel(i_beat) +: WORD_W] <= i_mem_rdata;
      end
    end
  end

  assign o_rdata       = r_rdata;
  assign o_mem_address = r_mem_address;
  assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: rtl/pmem_line_controller.sv
// Line-to-word bridge: serves one 128-bit pmem request as eight 16-bit memory beats.
module pmem_line_controller
  import pmem_line_controller_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  lc3b_word pmem_address,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_line pmem_wdata,
  output lc3b_line pmem_rdata,
  output logic     pmem_resp,
  output lc3b_word mem_address,
  output logic     mem_read,
  output logic     mem_write,
  output lc3b_word mem_wdata,
  input  lc3b_word mem_rdata,
  input  logic     mem_resp
);

  logic  w_load;
  logic  w_load_wdata;
  logic  w_capture;
  beat_t w_beat;
  beat_t w_beat_next;

  pmem_line_control u_control (
    .clk            (clk),
    .rst            (rst),
    .i_read         (pmem_read),
    .i_write        (pmem_write),
    .i_mem_resp     (mem_resp),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_pmem_resp    (pmem_resp),
    .o_load_c       (w_load),
    .o_load_wdata_c (w_load_wdata),
    .o_capture_c    (w_capture),
    .o_beat         (w_beat),
    .o_beat_next_c  (w_beat_next)
  );

  pmem_line_datapath u_datapath (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_load_wdata  (w_load_wdata),
    .i_capture     (w_capture),
    .i_beat        (w_beat),
    .i_beat_next   (w_beat_next),
    .i_address     (pmem_address),
    .i_wdata       (pmem_wdata),
    .i_mem_rdata   (mem_rdata),
    .o_rdata       (pmem_rdata),
    .o_mem_address (mem_address),
    .o_mem_wdata   (mem_wdata)
  );

endmodule

// File: tb/tb_pmem_line_controller.sv
// Directed self-checking bench for pmem_line_controller.
module tb_pmem_line_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;

  int total = 0;
  int bad   = 0;
  int abs_cyc = 0;

  logic [15:0] log_addr [8];
  logic [15:0] log_wd   [8];
  int n_rd, n_wr, resp_cyc, resp_cnt, stab_err, timed_out, first_abs, resp_abs;

  pmem_line_controller dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  // Issues one line request and plays word memory; returns in the pmem_resp cycle
  // (or in the first cycle of stop_beat). Cycle 1 is the cycle after the request edge.
  task automatic run_line(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [127:0] wd, input int waits, input logic [15:0] dbase,
                          input int chg_beat, input int stop_beat);
    int beats;
    int wctr;
    logic [15:0] cur;
    bit done;
    beats = 0; wctr = 0; cur = '0; done = 1'b0;
    n_rd = 0; n_wr = 0; resp_cyc = -1; resp_cnt = 0; stab_err = 0;
    timed_out = 0; first_abs = -1; resp_abs = -1;
    for (int i = 0; i < 8; i++) begin
      log_addr[i] = 16'hxxxx;
      log_wd[i]   = 16'hxxxx;
    end
    @(negedge clk);
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd; mem_resp = 1'b0;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (pmem_resp) begin
        resp_cnt++; resp_cyc = cyc; resp_abs = abs_cyc;
        pmem_read = 1'b0; pmem_write = 1'b0; done = 1'b1;
      end else if (mem_read || mem_write) begin
        if (first_abs < 0) first_abs = abs_cyc;
        if (wctr == 0) cur = mem_address;
        else if (mem_address !== cur) stab_err++;
        if (beats == chg_beat) pmem_address = 16'hFFF0;
        if (beats == stop_beat) begin
          done = 1'b1;
        end else if (wctr < waits) begin
          wctr++;
        end else begin
          mem_resp  = 1'b1;
          mem_rdata = mem_read ? dbase + 16'(beats) : 16'hDEAD;
          if (beats < 8) begin
            log_addr[beats] = mem_address;
            log_wd[beats]   = mem_wdata;
          end
          if (mem_read)  n_rd++;
          if (mem_write) n_wr++;
          beats++; wctr = 0;
        end
      end
    end
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
    pmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    #1;
    total++;
    if ({pmem_resp, mem_read, mem_write} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes: got %b want 000", {pmem_resp, mem_read, mem_write});
    end
    total++;
    if (mem_address !== 16'h0 || mem_wdata !== 16'h0) begin
      bad++; $display("FAIL reset_mem_bus: got %h/%h want 0000/0000", mem_address, mem_wdata);
    end
    total++;
    if (pmem_rdata !== 128'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", pmem_rdata);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({pmem_resp, mem_read, mem_write} !== 3'b000) begin
      bad++; $display("FAIL idle_after_reset: got %b want 000", {pmem_resp, mem_read, mem_write});
    end
  endtask

  task automatic test_zero_wait_read();
    run_line(1'b1, 1'b0, 16'h1237, '0, 0, 16'hA000, -1, -1);
    total++;
    if (resp_cyc != 9 || resp_cnt != 1) begin
      bad++; $display("FAIL zw_resp_cycle: got %0d want 9", resp_cyc);
    end
    total++;
    if (n_rd != 8 || n_wr != 0) begin
      bad++; $display("FAIL zw_beats: got rd=%0d wr=%0d want rd=8 wr=0", n_rd, n_wr);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (log_addr[i] !== 16'h1230 + 16'(2 * i)) begin
        bad++; $display("FAIL zw_addr%0d: got %h want %h", i, log_addr[i], 16'h1230 + 16'(2 * i));
      end
    end
    total++;
    if (pmem_rdata !== 128'hA007_A006_A005_A004_A003_A002_A001_A000) begin
      bad++; $display("FAIL zw_rdata: got %h want A007A006A005A004A003A002A001A000", pmem_rdata);
    end
    @(negedge clk);
    total++;
    if (pmem_resp !== 1'b0 || mem_read !== 1'b0) begin
      bad++; $display("FAIL zw_resp_pulse: got resp=%b rd=%b want 0 0", pmem_resp, mem_read);
    end
  endtask

  task automatic test_write_waits();
    run_line(1'b0, 1'b1, 16'h4000, 128'h0F0E0D0C0B0A09080706050403020100, 2, 16'h0, -1, -1);
    total++;
    if (resp_cyc != 25) begin
      bad++; $display("FAIL wr_resp_cycle: got %0d want 25", resp_cyc);
    end
    total++;
    if (n_wr != 8 || n_rd != 0) begin
      bad++; $display("FAIL wr_beats: got wr=%0d rd=%0d want wr=8 rd=0", n_wr, n_rd);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (log_addr[i] !== 16'h4000 + 16'(2 * i) || log_wd[i] !== 16'h0100 + 16'(16'h0202 * i)) begin
        bad++;
        $display("FAIL wr_beat%0d: got addr=%h data=%h want addr=%h data=%h", i, log_addr[i],
                 log_wd[i], 16'h4000 + 16'(2 * i), 16'h0100 + 16'(16'h0202 * i));
      end
    end
    total++;
    if (stab_err != 0) begin
      bad++; $display("FAIL wr_addr_stable: got %0d changes want 0", stab_err);
    end
    total++;
    if (pmem_rdata !== 128'hA007_A006_A005_A004_A003_A002_A001_A000) begin
      bad++; $display("FAIL wr_rdata_held: got %h want A007A006A005A004A003A002A001A000", pmem_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    run_line(1'b1, 1'b1, 16'h2000, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 0, 16'hB000, -1, -1);
    total++;
    if (n_rd != 8 || n_wr != 0) begin
      bad++; $display("FAIL sim_read_wins: got rd=%0d wr=%0d want rd=8 wr=0", n_rd, n_wr);
    end
    total++;
    if (resp_cyc != 9) begin
      bad++; $display("FAIL sim_resp_cycle: got %0d want 9", resp_cyc);
    end
    total++;
    if (pmem_rdata !== 128'hB007_B006_B005_B004_B003_B002_B001_B000) begin
      bad++; $display("FAIL sim_rdata: got %h want B007B006B005B004B003B002B001B000", pmem_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int stray;
    run_line(1'b1, 1'b0, 16'h3456, '0, 0, 16'hE000, -1, 3);
    total++;
    if (timed_out != 0 || mem_read !== 1'b1 || mem_address !== 16'h3456) begin
      bad++; $display("FAIL rst_beat3_reached: got rd=%b addr=%h want 1 3456", mem_read, mem_address);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({pmem_resp, mem_read, mem_write} !== 3'b000 || mem_address !== 16'h0 ||
        mem_wdata !== 16'h0 || pmem_rdata !== 128'h0) begin
      bad++;
      $display("FAIL rst_abort_outputs: got resp=%b rd=%b wr=%b addr=%h wd=%h rdata=%h want all 0",
               pmem_resp, mem_read, mem_write, mem_address, mem_wdata, pmem_rdata);
    end
    pmem_read = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pmem_resp || mem_read || mem_write) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL rst_no_resp: got %0d active cycles want 0", stray);
    end
    run_line(1'b1, 1'b0, 16'h3000, '0, 0, 16'hA000, -1, -1);
    total++;
    if (resp_cyc != 9 || log_addr[0] !== 16'h3000 || log_addr[7] !== 16'h300E) begin
      bad++; $display("FAIL rst_fresh_read: got cyc=%0d a0=%h a7=%h want 9 3000 300E",
                      resp_cyc, log_addr[0], log_addr[7]);
    end
    total++;
    if (pmem_rdata !== 128'hA007_A006_A005_A004_A003_A002_A001_A000) begin
      bad++; $display("FAIL rst_fresh_rdata: got %h want A007A006A005A004A003A002A001A000", pmem_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int rd_resp_abs;
    run_line(1'b1, 1'b0, 16'h1000, '0, 0, 16'hC000, -1, -1);
    rd_resp_abs = resp_abs;
    total++;
    if (resp_cyc != 9) begin
      bad++; $display("FAIL b2b_read_resp: got %0d want 9", resp_cyc);
    end
    run_line(1'b0, 1'b1, 16'h8000, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 0, 16'h0, -1, -1);
    total++;
    if (first_abs != rd_resp_abs + 2) begin
      bad++; $display("FAIL b2b_write_start: got %0d want %0d", first_abs, rd_resp_abs + 2);
    end
    total++;
    if (log_addr[0] !== 16'h8000 || log_wd[0] !== 16'h0000 || log_wd[7] !== 16'h7777 || n_wr != 8) begin
      bad++; $display("FAIL b2b_write_beats: got a0=%h d0=%h d7=%h n=%0d want 8000 0000 7777 8",
                      log_addr[0], log_wd[0], log_wd[7], n_wr);
    end
    total++;
    if (pmem_rdata !== 128'hC007_C006_C005_C004_C003_C002_C001_C000) begin
      bad++; $display("FAIL b2b_rdata: got %h want C007C006C005C004C003C002C001C000", pmem_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_input_stability();
    run_line(1'b1, 1'b0, 16'h5000, '0, 1, 16'hD000, 4, -1);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (log_addr[i] !== 16'h5000 + 16'(2 * i)) begin
        bad++; $display("FAIL stab_addr%0d: got %h want %h", i, log_addr[i], 16'h5000 + 16'(2 * i));
      end
    end
    total++;
    if (stab_err != 0 || resp_cyc != 17) begin
      bad++; $display("FAIL stab_timing: got changes=%0d cyc=%0d want 0 17", stab_err, resp_cyc);
    end
    total++;
    if (pmem_rdata !== 128'hD007_D006_D005_D004_D003_D002_D001_D000) begin
      bad++; $display("FAIL stab_rdata: got %h want D007D006D005D004D003D002D001D000", pmem_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
    test_input_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
